// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: bundle of the command/response port and the shared APB bus
// between the bridge and its two slaves.
//   req_*    : command port (valid/ready), driven by the requester
//   rsp_*    : one-cycle response strobe with read data and timeout error
//   PSELx, PENABLE, PWRITE, PADDR, PWDATA : APB request side, driven by the bridge
//   PREADYx, PRDATAx                      : APB slave replies
// Modport master is the bridge view; modport slave is the surrounding environment.
interface apb_master_bridge_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [8:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       PSEL1;
    logic       PSEL2;
    logic       PENABLE;
    logic       PWRITE;
    logic [7:0] PADDR;
    logic [7:0] PWDATA;
    logic       PREADY1;
    logic       PREADY2;
    logic [7:0] PRDATA1;
    logic [7:0] PRDATA2;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  PREADY1, PREADY2, PRDATA1, PRDATA2,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output PREADY1, PREADY2, PRDATA1, PRDATA2,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB master for two slaves on a shared bus.
// Accepts one read/write command in IDLE, runs SETUP then ACCESS toward the slave chosen
// by req_addr[8], and returns a one-cycle rsp_valid strobe with read data or a timeout
// error. All outputs are registered.
//   PCLK   : clock, rising edge
//   PRESET : synchronous active-high reset
//   bus    : apb_master_bridge_if.master (command port, response port, APB bus)
module apb_master_bridge #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic                  PCLK,
    input logic                  PRESET,
    apb_master_bridge_if.master  bus
);

    // Abort fires on the ACCESS cycle that would make the wait count reach TIMEOUT.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e     state_q, state_d;
    logic       req_ready_q, req_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q, rsp_err_d;
    logic       psel1_q, psel1_d;
    logic       psel2_q, psel2_d;
    logic       penable_q, penable_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Only the addressed slave is listened to; psel2_q is valid throughout SETUP/ACCESS.
    logic       pready_sel;
    logic [7:0] prdata_sel;
    assign pready_sel = psel2_q ? bus.PREADY2 : bus.PREADY1;
    assign prdata_sel = psel2_q ? bus.PRDATA2 : bus.PRDATA1;

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel1_d     = psel1_q;
        psel2_d     = psel2_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    state_d     = StSetup;
                    req_ready_d = 1'b0;
                    psel1_d     = ~bus.req_addr[8];
                    psel2_d     = bus.req_addr[8];
                    pwrite_d    = bus.req_write;
                    paddr_d     = bus.req_addr[7:0];
                    pwdata_d    = bus.req_wdata;
                end
            end
            StSetup: begin
                state_d    = StAccess;
                penable_d  = 1'b1;
                wait_cnt_d = 8'd0;
            end
            StAccess: begin
                // Completion wins over timeout when both happen on the same cycle.
                if (pready_sel || (wait_cnt_q == WaitLast)) begin
                    state_d     = StIdle;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel1_d     = 1'b0;
                    psel2_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = ~pready_sel;
                    rsp_rdata_d = (pready_sel && !pwrite_q) ? prdata_sel : 8'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d     = StIdle;
                req_ready_d = 1'b1;
                psel1_d     = 1'b0;
                psel2_d     = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
            rsp_err_q   <= 1'b0;
            psel1_q     <= 1'b0;
            psel2_q     <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 8'd0;
            pwdata_q    <= 8'd0;
            wait_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel1_q     <= psel1_d;
            psel2_q     <= psel2_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.PSEL1     = psel1_q;
    assign bus.PSEL2     = psel2_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed cases followed by random transfers.
// Each issued command pushes its expected response (error flag, data, response cycle);
// a negedge monitor pops on rsp_valid and also checks bus phases against the command.
module tb_apb_master_bridge;

    localparam int unsigned TIMEOUT = 16;

    logic PCLK = 1'b0;
    logic PRESET;

    apb_master_bridge_if bus ();

    apb_master_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       err;
        logic [7:0] rdata;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    // Current command as seen by the monitor. Active window is cyc in [cur_a, cur_a+cur_delta):
    // cur_a is the cycle right after the accept edge (SETUP), cur_a+cur_delta the response cycle.
    int         cur_a = -100;
    int         cur_delta = 0;
    logic       cur_sel2 = 1'b0;
    logic       cur_write = 1'b0;
    logic [7:0] cur_addr = 8'd0;
    logic [7:0] cur_wdata = 8'd0;
    bit         hold_ok = 1'b0;
    logic [7:0] last_rdata = 8'd0;
    logic       last_err = 1'b0;

    // Slave behaviour: number of PREADY-low ACCESS cycles for the current transfer.
    int         plan_w = 0;
    logic [7:0] slave_mem [2][256];
    logic [7:0] ref_mem [2][256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Slave models: selected slave answers after plan_w low ACCESS cycles; everything else
    // (unselected PREADY, not-ready PRDATA) is random noise the bridge must ignore.
    int acc_cnt = 0;
    always @(negedge PCLK) begin
        int  s;
        bit  rdy;
        bus.PREADY1 = 1'($urandom);
        bus.PREADY2 = 1'($urandom);
        bus.PRDATA1 = 8'($urandom);
        bus.PRDATA2 = 8'($urandom);
        if (bus.PENABLE && (bus.PSEL1 || bus.PSEL2)) begin
            s   = bus.PSEL2 ? 1 : 0;
            rdy = (acc_cnt >= plan_w);
            acc_cnt++;
            if (s == 1) bus.PREADY2 = rdy;
            else        bus.PREADY1 = rdy;
            if (rdy) begin
                if (bus.PWRITE) slave_mem[s][bus.PADDR] = bus.PWDATA;
                else if (s == 1) bus.PRDATA2 = slave_mem[1][bus.PADDR];
                else             bus.PRDATA1 = slave_mem[0][bus.PADDR];
            end
        end else begin
            acc_cnt = 0;
        end
    end

    // Monitor
    int mon_k;
    always @(negedge PCLK) begin
        exp_t e;
        mon_k = cyc - cur_a;
        check("psel_exclusive", 32'(bus.PSEL1 & bus.PSEL2), 32'd0);
        if (mon_k >= 0 && mon_k < cur_delta) begin
            check("psel1", 32'(bus.PSEL1), 32'(!cur_sel2));
            check("psel2", 32'(bus.PSEL2), 32'(cur_sel2));
            check("penable", 32'(bus.PENABLE), 32'(mon_k >= 1));
            check("paddr", 32'(bus.PADDR), 32'(cur_addr));
            check("pwdata", 32'(bus.PWDATA), 32'(cur_wdata));
            check("pwrite", 32'(bus.PWRITE), 32'(cur_write));
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
        end else begin
            check("psel1_idle", 32'(bus.PSEL1), 32'd0);
            check("psel2_idle", 32'(bus.PSEL2), 32'd0);
            check("penable_idle", 32'(bus.PENABLE), 32'd0);
            check("req_ready_idle", 32'(bus.req_ready), 32'd1);
            if (hold_ok) begin
                check("paddr_hold", 32'(bus.PADDR), 32'(cur_addr));
                check("pwdata_hold", 32'(bus.PWDATA), 32'(cur_wdata));
                check("pwrite_hold", 32'(bus.PWRITE), 32'(cur_write));
            end
        end
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp at cycle %0d: actual=1 required=0", cyc);
            end else begin
                e = exp_q.pop_front();
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                check("rsp_cycle", 32'(cyc), 32'(e.at));
                last_rdata = e.rdata;
                last_err   = e.err;
            end
        end else begin
            check("rsp_rdata_hold", 32'(bus.rsp_rdata), 32'(last_rdata));
            check("rsp_err_hold", 32'(bus.rsp_err), 32'(last_err));
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge PCLK);
        #1;
        while (!bus.req_ready) begin
            n++;
            if (n > 400) begin
                checks++;
                errors++;
                $display("FAIL req_ready_wait: actual=0 required=1 within 400 cycles");
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "bench stalled");
            end
            @(negedge PCLK);
            #1;
        end
    endtask

    // Drives one command into IDLE. Expected latency in edges after the accept edge:
    // w+2 for a normal completion (zero-wait response visible after edge 2),
    // TIMEOUT+1 when the slave stays low for TIMEOUT ACCESS cycles.
    task automatic issue(input logic wr, input logic [8:0] addr, input logic [7:0] wd,
                         input int w, input bit expect_rsp);
        exp_t e;
        int   s;
        s = addr[8] ? 1 : 0;
        cur_a     = cyc + 1;
        cur_sel2  = addr[8];
        cur_write = wr;
        cur_addr  = addr[7:0];
        cur_wdata = wd;
        plan_w    = w;
        hold_ok   = 1'b1;
        if (w >= int'(TIMEOUT)) cur_delta = int'(TIMEOUT) + 1;
        else                    cur_delta = w + 2;
        if (expect_rsp) begin
            e.err   = (w >= int'(TIMEOUT));
            e.rdata = (e.err || wr) ? 8'd0 : ref_mem[s][addr[7:0]];
            e.at    = cur_a + cur_delta;
            if (!e.err && wr) ref_mem[s][addr[7:0]] = wd;
            exp_q.push_back(e);
        end
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
    endtask

    task automatic do_xfer(input logic wr, input logic [8:0] addr, input logic [7:0] wd,
                           input int w, input bit hold_valid);
        int a;
        wait_ready();
        issue(wr, addr, wd, w, 1'b1);
        a = cur_a;
        @(negedge PCLK);
        #1;
        // Optionally keep presenting junk while busy; it must be ignored outside IDLE.
        while (hold_valid && (cyc < a + cur_delta - 1)) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'($urandom);
            bus.req_addr  = 9'($urandom);
            bus.req_wdata = 8'($urandom);
            @(negedge PCLK);
            #1;
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int a;
        int r;
        int w;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) begin
                slave_mem[s][i] = 8'($urandom);
                ref_mem[s][i]   = slave_mem[s][i];
            end
        end

        // Reset with a request pending must not start anything.
        PRESET        = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 9'h1A5;
        bus.req_wdata = 8'h77;
        repeat (2) @(negedge PCLK);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_psel", 32'({bus.PSEL1, bus.PSEL2, bus.PENABLE}), 32'd0);
        check("rst_pwrite", 32'(bus.PWRITE), 32'd0);
        check("rst_paddr", 32'(bus.PADDR), 32'd0);
        check("rst_pwdata", 32'(bus.PWDATA), 32'd0);
        #1;
        bus.req_valid = 1'b0;
        PRESET        = 1'b0;

        do_xfer(1'b1, 9'h012, 8'hA5, 0, 1'b0);
        do_xfer(1'b0, 9'h012, 8'h00, 0, 1'b0);
        slave_mem[1][8'hFF] = 8'h3C;
        ref_mem[1][8'hFF]   = 8'h3C;
        do_xfer(1'b0, 9'h1FF, 8'h00, 0, 1'b1);
        do_xfer(1'b1, 9'h1AB, 8'h5A, 3, 1'b0);
        do_xfer(1'b0, 9'h033, 8'h11, 100, 1'b1);
        do_xfer(1'b0, 9'h012, 8'h00, 0, 1'b0);
        do_xfer(1'b0, 9'h012, 8'h22, int'(TIMEOUT) - 1, 1'b0);

        // Reset during the second ACCESS cycle drops the command silently.
        wait_ready();
        issue(1'b0, 9'h040, 8'h99, 50, 1'b0);
        a = cur_a;
        cur_delta = 3;
        @(negedge PCLK);
        #1;
        bus.req_valid = 1'b0;
        while (cyc < a + 2) begin
            @(negedge PCLK);
            #1;
        end
        PRESET     = 1'b1;
        hold_ok    = 1'b0;
        last_rdata = 8'd0;
        last_err   = 1'b0;
        @(negedge PCLK);
        check("midrst_psel", 32'({bus.PSEL1, bus.PSEL2}), 32'd0);
        check("midrst_penable", 32'(bus.PENABLE), 32'd0);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("midrst_paddr", 32'(bus.PADDR), 32'd0);
        #1;
        PRESET = 1'b0;
        do_xfer(1'b0, 9'h1FF, 8'h00, 1, 1'b0);

        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)       w = int'($urandom_range(0, 3));
            else if (r == 6) w = int'(TIMEOUT) - 1;
            else if (r == 7) w = int'(TIMEOUT);
            else if (r == 8) w = int'($urandom_range(4, 14));
            else             w = 20;
            do_xfer(1'($urandom), 9'($urandom), 8'($urandom), w, 1'($urandom));
        end

        for (int n = 0; n < 60 && exp_q.size() > 0; n++) @(negedge PCLK);
        @(negedge PCLK);
        check("pending_rsp", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB master that sits directly upstream of the two APB slaves (slave1, slave2) and drives their shared bus. It accepts single read/write requests on a simple valid/ready command port, runs the APB SETUP/ACCESS sequence toward the addressed slave, and waits on that slave's PREADY. It returns read data or a write acknowledgement on a one-cycle response strobe. A wait-state timeout guarantees the bridge never hangs on a stalled slave.

## Interface

- TIMEOUT, default 16: maximum consecutive ACCESS cycles with PREADY low before the transfer is aborted (range 2–255).

- PCLK  input  1  the single clock; all logic is on the rising edge.
- PRESET  input  1  reset, synchronous, active-high.
- req_valid  input  1  command present.
- req_ready  output  1  bridge can accept a command (high only in IDLE).
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  9  bit 8 selects the slave (0 = slave1, 1 = slave2); bits 7:0 are the slave address.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle completion strobe.
- rsp_rdata  output  8  read data; 0 for writes and errors.
- rsp_err  output  1  timeout abort; valid with rsp_valid.
- PSEL1, PSEL2  output  1 each  slave selects; mutually exclusive.
- PENABLE  output  1  APB access phase.
- PWRITE  output  1  APB direction.
- PADDR  output  8  APB address.
- PWDATA  output  8  APB write data.
- PREADY1, PREADY2  input  1 each  slave ready signals.
- PRDATA1, PRDATA2  input  8 each  slave read data.

## Operation

- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE:
  - req_ready=1, PSELx=0, PENABLE=0.
  - When req_valid=1, latch req_write, req_addr and req_wdata, then go to SETUP.
- SETUP:
  - Exactly one cycle.
  - The selected PSELx is 1, PENABLE=0, and PADDR/PWRITE/PWDATA carry the latched command.
  - Next state is ACCESS.
- ACCESS:
  - The selected PSELx is 1 and PENABLE=1. Address, data and control are held stable.
  - Only the selected slave's PREADY is sampled; the other PREADY is ignored.
  - If PREADY is sampled high, the transfer completes and the next state is IDLE:
    - Read: capture the selected PRDATA into rsp_rdata.
    - Write: rsp_rdata=0.
    - rsp_err=0.
- Timeout:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle in which the selected PREADY is low.
  - When the counter reaches TIMEOUT, the transfer aborts: rsp_err=1, rsp_rdata=0, and the next state is IDLE.
  - PREADY high on the same cycle the counter reaches TIMEOUT counts as a normal completion; completion has priority over timeout.
- In IDLE, PADDR, PWRITE and PWDATA keep their last values; only PSELx and PENABLE drop.
- Writes have no side effect inside the bridge beyond the bus sequence.

## Timing

- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, PSEL1=PSEL2=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, wait counter=0.
- Let the accept edge be edge 0, i.e. the edge where req_valid=1 while in IDLE.
  - SETUP is the cycle after edge 0.
  - ACCESS begins after edge 1.
  - With zero wait states, PREADY is sampled high at edge 2.
  - rsp_valid=1 and req_ready=1 in the cycle after edge 2.
- Zero-wait throughput is one transfer per 3 cycles. A new request may be accepted in the same cycle rsp_valid is high.
- Each PREADY-low ACCESS cycle adds 1 cycle of latency.
- A timeout response appears TIMEOUT+2 cycles after the accept edge.
- rsp_valid is high for exactly one cycle per accepted command. rsp_rdata and rsp_err hold their values until the next response.
- req_valid is ignored outside IDLE; no queuing.
- PRESET asserted mid-transfer (SETUP or ACCESS): at that edge all outputs return to reset values with no response issued. The in-flight command is dropped.
- PSEL1 and PSEL2 are never high in the same cycle. PENABLE is never high without a PSELx.

## Test plan

- Reset: hold PRESET=1 for 2 cycles with req_valid=1 → all outputs at reset values, no PSELx asserted, no rsp_valid.
- Write slave1, then read slave1:
  - Write req_addr=0x012, req_wdata=0xA5 with the slave model PREADY zero-wait → PSEL1 SETUP 1 cycle then ACCESS 1 cycle, PADDR=0x12, PWDATA=0xA5, PWRITE=1; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
  - Read req_addr=0x012 → rsp_rdata=0xA5.
- Read slave2: req_addr=0x1FF with PRDATA2=0x3C → PSEL2=1 and PSEL1=0 throughout; rsp_rdata=0x3C.
- Wait states: PREADY2 low for 3 ACCESS cycles, then high → PENABLE high for 4 cycles, PADDR/PWDATA stable throughout, rsp_valid at accept+6. A toggling PREADY1 during the same transfer is ignored.
- Timeout:
  - TIMEOUT=16 with PREADY1 held low → abort, rsp_err=1 and rsp_rdata=0 at accept+18, bus idle afterwards; a following normal transfer succeeds.
  - PREADY1 rising on the 16th wait cycle → normal completion with rsp_err=0.
- Reset mid-ACCESS: assert PRESET during the second ACCESS cycle → next cycle PSELx=0, PENABLE=0, no rsp_valid; a subsequent request completes normally.
